// File: rtl/cgol_pkg.sv
// Shared types, constants and helpers for the cellular-automaton engine.
//   state_t      : engine state encoding
//   WINDOW_SIZE  : cells in the 3x3 neighbourhood window
//   SELF_IDX     : window bit holding the cell under evaluation
//   win_dr/win_dc: row/column offset (0..2, i.e. -1..+1) of window slot k
//   popcount9    : number of set bits in a 9-bit window
package cgol_pkg;

  localparam int unsigned WINDOW_SIZE = 9;
  localparam int unsigned SELF_IDX    = 4;
  localparam int unsigned K_W         = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_EVAL    = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Row offset of window slot k (slots are walked row-major).
  function automatic logic [1:0] win_dr(input logic [K_W-1:0] k);
    return 2'(k / 4'd3);
  endfunction

  // Column offset of window slot k.
  function automatic logic [1:0] win_dc(input logic [K_W-1:0] k);
    return 2'(k % 4'd3);
  endfunction

  function automatic logic [3:0] popcount9(input logic [WINDOW_SIZE-1:0] w);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < int'(WINDOW_SIZE); i++) begin
      n = n + 4'(w[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cgol_rule_eval.sv
// Combinational birth/survival rule evaluation for one cell.
//   window : 9-bit neighbourhood, bit SELF_IDX is the cell itself
//   next_c : next-generation value of the cell
module cgol_rule_eval
  import cgol_pkg::*;
#(
  parameter logic [8:0] RULE_B = 9'b000001000,
  parameter logic [8:0] RULE_S = 9'b000001100
) (
  input  logic [WINDOW_SIZE-1:0] window,
  output logic                   next_c
);

  logic [3:0] total;
  logic [3:0] neighbours;

  // Neighbour count excludes the cell itself, so it ranges 0..8.
  always_comb begin
    total      = popcount9(window);
    neighbours = total - 4'(window[SELF_IDX]);
    next_c     = window[SELF_IDX] ? RULE_S[neighbours] : RULE_B[neighbours];
  end

endmodule

// File: rtl/cgol_engine.sv
// Life-like cellular-automaton generation engine for a ROWS x COLS board in
// double-banked external single-port memory. Each generation reads bank
// o_bank and writes bank ~o_bank, one cell at a time.
// Optional feature macro: CGOL_WRAP_EN (toroidal boundary); when undefined
// the boundary is dead and out-of-grid window slots issue no memory request.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   i_start               start one generation (accepted in idle only)
//   o_busy, o_done        generation in progress / one-cycle completion pulse
//   o_bank, o_gen_count   bank of the latest complete board / generation count
//   o_mem_req/we/addr/wdata, i_mem_gnt, i_mem_rdata
//                         single-port memory handshake; read data arrives
//                         one cycle after a granted read
module cgol_engine
  import cgol_pkg::*;
#(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned COLS   = 8,
  parameter logic [8:0]  RULE_B = 9'b000001000,
  parameter logic [8:0]  RULE_S = 9'b000001100,
  localparam int unsigned CELL_W = $clog2(ROWS * COLS),
  localparam int unsigned ADDR_W = CELL_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_bank,
  output logic [15:0]       o_gen_count,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rdata
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
`ifdef CGOL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(WINDOW_SIZE - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [ROW_W-1:0]       row;
  logic [COL_W-1:0]       col;
  logic [K_W-1:0]         k;
  logic [WINDOW_SIZE-1:0] window;
  logic                   rd_pending;
  logic [K_W-1:0]         rd_idx;
  logic                   next_cell;
  logic                   eval_next_c;

  logic [1:0]             dr;
  logic [1:0]             dc;
  logic [ROW_W-1:0]       nb_row;
  logic [COL_W-1:0]       nb_col;
  logic                   row_ok;
  logic                   col_ok;
  logic                   nb_valid;
  logic [CELL_W-1:0]      nb_addr;
  logic [CELL_W-1:0]      cell_addr;
  logic                   last_cell;
  logic                   fetch_step;

  // Neighbour coordinates of window slot k; wrap by explicit compare.
  always_comb begin
    dr     = win_dr(k);
    dc     = win_dc(k);
    nb_row = row;
    nb_col = col;
    row_ok = 1'b1;
    col_ok = 1'b1;
    case (dr)
      2'd0: begin
        if (row == '0) begin
          nb_row = ROW_LAST;
          row_ok = WRAP_EN;
        end else begin
          nb_row = row - ROW_W'(1);
        end
      end
      2'd2: begin
        if (row == ROW_LAST) begin
          nb_row = '0;
          row_ok = WRAP_EN;
        end else begin
          nb_row = row + ROW_W'(1);
        end
      end
      default: nb_row = row;
    endcase
    case (dc)
      2'd0: begin
        if (col == '0) begin
          nb_col = COL_LAST;
          col_ok = WRAP_EN;
        end else begin
          nb_col = col - COL_W'(1);
        end
      end
      2'd2: begin
        if (col == COL_LAST) begin
          nb_col = '0;
          col_ok = WRAP_EN;
        end else begin
          nb_col = col + COL_W'(1);
        end
      end
      default: nb_col = col;
    endcase
    nb_valid   = row_ok & col_ok;
    nb_addr    = CELL_W'(32'(nb_row) * COLS + 32'(nb_col));
    cell_addr  = CELL_W'(32'(row) * COLS + 32'(col));
    last_cell  = (row == ROW_LAST) && (col == COL_LAST);
    // Out-of-grid slots make no request but still take one cycle.
    fetch_step = ~nb_valid | i_mem_gnt;
  end

  cgol_rule_eval #(
    .RULE_B (RULE_B),
    .RULE_S (RULE_S)
  ) u_rule_eval (
    .window (window),
    .next_c (eval_next_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_start) state_nxt = S_FETCH;
      S_FETCH:   if (fetch_step && (k == K_LAST)) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_EVAL;
      S_EVAL:    state_nxt = S_WRITE;
      S_WRITE:   if (i_mem_gnt) state_nxt = last_cell ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Memory request decode from registered state.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = 1'b0;
    case (state)
      S_FETCH: begin
        o_mem_req  = nb_valid;
        o_mem_addr = {o_bank, nb_addr};
      end
      S_WRITE: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {~o_bank, cell_addr};
        o_mem_wdata = next_cell;
      end
      default: ;
    endcase
  end

  // Datapath: cell/window counters, read capture, status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row         <= '0;
      col         <= '0;
      k           <= '0;
      window      <= '0;
      rd_pending  <= 1'b0;
      rd_idx      <= '0;
      next_cell   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_bank      <= 1'b0;
      o_gen_count <= '0;
    end else begin
      rd_pending <= 1'b0;
      o_done     <= 1'b0;
      // Read data lands one cycle after its grant.
      if (rd_pending) window[rd_idx] <= i_mem_rdata;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            row    <= '0;
            col    <= '0;
            k      <= '0;
            o_busy <= 1'b1;
          end
        end
        S_FETCH: begin
          if (fetch_step) begin
            if (nb_valid) begin
              rd_pending <= 1'b1;
              rd_idx     <= k;
            end else begin
              window[k] <= 1'b0;
            end
            k <= (k == K_LAST) ? '0 : k + K_W'(1);
          end
        end
        S_EVAL: next_cell <= eval_next_c;
        S_WRITE: begin
          if (i_mem_gnt) begin
            if (last_cell) begin
              o_done      <= 1'b1;
              o_busy      <= 1'b0;
              o_bank      <= ~o_bank;
              o_gen_count <= o_gen_count + 16'd1;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cgol_engine.sv
// Bench for cgol_engine: two instances (8x8 Conway, 6x5 HighLife) on a
// behavioural single-port memory; expected cell writes are queued per
// generation from a board model and compared as the engine writes them.
module tb_cgol_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic        start0 = 1'b0, busy0, done0, bank0, req0, we0, wdata0;
  logic        gnt0 = 1'b1, rdata0 = 1'b0;
  logic [6:0]  addr0;
  logic [15:0] gen0;
  logic        start1 = 1'b0, busy1, done1, bank1, req1, we1, wdata1;
  logic        gnt1 = 1'b1, rdata1 = 1'b0;
  logic [5:0]  addr1;
  logic [15:0] gen1;

  cgol_engine u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start0), .o_busy(busy0), .o_done(done0),
    .o_bank(bank0), .o_gen_count(gen0), .o_mem_req(req0), .o_mem_we(we0),
    .o_mem_addr(addr0), .o_mem_wdata(wdata0), .i_mem_gnt(gnt0), .i_mem_rdata(rdata0)
  );

  cgol_engine #(.ROWS(6), .COLS(5), .RULE_B(9'b001001000), .RULE_S(9'b000001100)) u_dut_hl (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_bank(bank1), .o_gen_count(gen1), .o_mem_req(req1), .o_mem_we(we1),
    .o_mem_addr(addr1), .o_mem_wdata(wdata1), .i_mem_gnt(gnt1), .i_mem_rdata(rdata1)
  );

  int n_vec = 0;
  int n_err = 0;

  logic       mem [2][128];
  logic       pend [2];
  bit         gnt_rand [2];
  int         stalls [2];
  int         reads [2];
  int         wr_cnt [2];
  int         exp_bank [2];
  int         exp_gen [2];
  int         rows_ [2] = '{8, 6};
  int         cols_ [2] = '{8, 5};
  int         cw_ [2] = '{6, 5};
  logic [8:0] rule_b_ [2] = '{9'b000001000, 9'b001001000};
  logic [8:0] rule_s_ [2] = '{9'b000001100, 9'b000001100};
  logic [15:0] sb0[$];
  logic [15:0] sb1[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx(input int u, input int b, input int r, input int c);
    return (b << cw_[u]) + r * cols_[u] + c;
  endfunction

  function automatic int sb_size(input int u);
    return (u == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic [15:0] sb_pop(input int u);
    if (u == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  // Board model: next value of (r,c) from bank b.
  function automatic logic golden(input int u, input int b, input int r, input int c);
    int n;
    int rr;
    int cc;
    logic [8:0] rule;
    n = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr == 0 && dc == 0) continue;
        rr = r + dr;
        cc = c + dc;
`ifdef CGOL_WRAP_EN
        rr = (rr + rows_[u]) % rows_[u];
        cc = (cc + cols_[u]) % cols_[u];
`else
        if (rr < 0 || rr >= rows_[u] || cc < 0 || cc >= cols_[u]) continue;
`endif
        if (mem[u][idx(u, b, rr, cc)] == 1'b1) n++;
      end
    end
    rule = (mem[u][idx(u, b, r, c)] == 1'b1) ? rule_s_[u] : rule_b_[u];
    return rule[n];
  endfunction

  task automatic push_expect(input int u);
    logic [15:0] e;
    for (int r = 0; r < rows_[u]; r++) begin
      for (int c = 0; c < cols_[u]; c++) begin
        e = 16'(idx(u, 1 - exp_bank[u], r, c) * 2 + int'(golden(u, exp_bank[u], r, c)));
        if (u == 0) sb0.push_back(e);
        else sb1.push_back(e);
      end
    end
  endtask

  // Memory model: grants decided mid-cycle, read data presented next cycle.
  always @(negedge clk) begin
    logic r_req, r_we, r_wd, g;
    int a;
    rdata0 = pend[0];
    rdata1 = pend[1];
    gnt0 = gnt_rand[0] ? 1'($urandom_range(0, 1)) : 1'b1;
    gnt1 = gnt_rand[1] ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int u = 0; u < 2; u++) begin
      r_req = (u == 0) ? req0 : req1;
      r_we  = (u == 0) ? we0 : we1;
      r_wd  = (u == 0) ? wdata0 : wdata1;
      g     = (u == 0) ? gnt0 : gnt1;
      a     = (u == 0) ? int'(addr0) : int'(addr1);
      if (rst_n && r_req) begin
        if (!g) begin
          stalls[u]++;
        end else if (r_we) begin
          wr_cnt[u]++;
          if (sb_size(u) == 0) check_eq("sb_empty", 32'(sb_size(u)), 32'd1);
          else check_eq("wr_cell", 32'(a * 2 + int'(r_wd)), 32'(sb_pop(u)));
          mem[u][a] = r_wd;
        end else begin
          reads[u]++;
          pend[u] = mem[u][a];
        end
      end
    end
  end

  task automatic set_start(input int u, input logic v);
    if (u == 0) start0 = v;
    else start1 = v;
  endtask

  task automatic run_gen(input int u, input bit rnd, input int restart_at);
    int n;
    int rd_exp;
    logic d, bs, bk;
    logic [15:0] gc;
    push_expect(u);
    gnt_rand[u] = rnd;
    @(negedge clk);
    set_start(u, 1'b1);
    stalls[u] = 0;
    reads[u]  = 0;
    @(negedge clk);
    set_start(u, 1'b0);
    n = 1;
    check_eq("busy_on", 32'((u == 0) ? busy0 : busy1), 32'd1);
    d = (u == 0) ? done0 : done1;
    while (!d && n < 20000) begin
      @(negedge clk);
      n++;
      set_start(u, (n == restart_at) ? 1'b1 : 1'b0);
      d = (u == 0) ? done0 : done1;
    end
    set_start(u, 1'b0);
    check_eq("latency", 32'(n), 32'(12 * rows_[u] * cols_[u] + 1 + stalls[u]));
`ifdef CGOL_WRAP_EN
    rd_exp = 9 * rows_[u] * cols_[u];
`else
    rd_exp = (3 * rows_[u] - 2) * (3 * cols_[u] - 2);
`endif
    check_eq("reads", 32'(reads[u]), 32'(rd_exp));
    exp_bank[u] = 1 - exp_bank[u];
    exp_gen[u]  = (exp_gen[u] + 1) & 16'hFFFF;
    bk = (u == 0) ? bank0 : bank1;
    gc = (u == 0) ? gen0 : gen1;
    bs = (u == 0) ? busy0 : busy1;
    check_eq("bank", 32'(bk), 32'(exp_bank[u]));
    check_eq("gen_count", 32'(gc), 32'(exp_gen[u]));
    check_eq("busy_at_done", 32'(bs), 32'd0);
    check_eq("sb_left", 32'(sb_size(u)), 32'd0);
    @(negedge clk);
    check_eq("done_pulse", 32'((u == 0) ? done0 : done1), 32'd0);
    gnt_rand[u] = 1'b0;
  endtask

  task automatic clear_mem(input int u);
    for (int i = 0; i < 128; i++) mem[u][i] = 1'b0;
  endtask

  task automatic set_cell(input int u, input int r, input int c);
    mem[u][idx(u, exp_bank[u], r, c)] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int live;
    for (int u = 0; u < 2; u++) begin
      pend[u] = 1'b0; gnt_rand[u] = 1'b0; stalls[u] = 0; reads[u] = 0;
      wr_cnt[u] = 0; exp_bank[u] = 0; exp_gen[u] = 0;
      clear_mem(u);
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_done", 32'(done0), 32'd0);
    check_eq("rst_bank", 32'(bank0), 32'd0);
    check_eq("rst_gen", 32'(gen0), 32'd0);
    check_eq("rst_req", 32'(req0), 32'd0);
    check_eq("rst_busy_hl", 32'(busy1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Blinker: horizontal row 3 cols 2..4 becomes vertical col 3 rows 2..4.
    set_cell(0, 3, 2); set_cell(0, 3, 3); set_cell(0, 3, 4);
    run_gen(0, 1'b0, -1);
    for (int r = 2; r <= 4; r++) check_eq("blinker_col", 32'(mem[0][idx(0, 1, r, 3)]), 32'd1);
    check_eq("blinker_l", 32'(mem[0][idx(0, 1, 3, 2)]), 32'd0);
    check_eq("blinker_r", 32'(mem[0][idx(0, 1, 3, 4)]), 32'd0);

    // Glider in the bottom-right corner, four generations.
    clear_mem(0);
    set_cell(0, 5, 6); set_cell(0, 6, 7); set_cell(0, 7, 5); set_cell(0, 7, 6); set_cell(0, 7, 7);
    repeat (4) run_gen(0, 1'b0, -1);
`ifdef CGOL_WRAP_EN
    check_eq("glider_a", 32'(mem[0][idx(0, exp_bank[0], 6, 7)]), 32'd1);
    check_eq("glider_b", 32'(mem[0][idx(0, exp_bank[0], 7, 0)]), 32'd1);
    check_eq("glider_c", 32'(mem[0][idx(0, exp_bank[0], 0, 6)]), 32'd1);
    check_eq("glider_d", 32'(mem[0][idx(0, exp_bank[0], 0, 7)]), 32'd1);
    check_eq("glider_e", 32'(mem[0][idx(0, exp_bank[0], 0, 0)]), 32'd1);
    live = 0;
    for (int i = 0; i < 64; i++) if (mem[0][idx(0, exp_bank[0], 0, 0) + i] == 1'b1) live++;
    check_eq("glider_pop", 32'(live), 32'd5);
`endif

    // 6x5 board, random contents, random grant stalls.
    for (int i = 0; i < 30; i++) mem[1][idx(1, exp_bank[1], 0, 0) + i] = 1'($urandom_range(0, 1));
    run_gen(1, 1'b1, -1);
    run_gen(1, 1'b1, -1);

    // Dead cell with six neighbours: born under HighLife, stays dead under Conway.
    for (int u = 0; u < 2; u++) begin
      clear_mem(u);
      set_cell(u, 1, 1); set_cell(u, 1, 2); set_cell(u, 1, 3);
      set_cell(u, 2, 1); set_cell(u, 3, 1); set_cell(u, 3, 2);
    end
    run_gen(1, 1'b0, -1);
    check_eq("highlife_b6", 32'(mem[1][idx(1, exp_bank[1], 2, 2)]), 32'd1);
    run_gen(0, 1'b0, -1);
    check_eq("conway_b6", 32'(mem[0][idx(0, exp_bank[0], 2, 2)]), 32'd0);

    // Reset in the middle of a generation.
    push_expect(0);
    @(negedge clk);
    start0 = 1'b1;
    wr_cnt[0] = 0;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (wr_cnt[0] < 20 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_cell20", 32'(wr_cnt[0]), 32'd20);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy", 32'(busy0), 32'd0);
    check_eq("mid_rst_done", 32'(done0), 32'd0);
    check_eq("mid_rst_bank", 32'(bank0), 32'd0);
    check_eq("mid_rst_gen", 32'(gen0), 32'd0);
    check_eq("mid_rst_req", 32'(req0), 32'd0);
    check_eq("mid_rst_addr", 32'(addr0), 32'd0);
    rst_n = 1'b1;
    sb0.delete();
    sb1.delete();
    for (int u = 0; u < 2; u++) begin
      exp_bank[u] = 0;
      exp_gen[u]  = 0;
    end
    @(negedge clk);
    check_eq("post_rst_idle_req", 32'(req0), 32'd0);
    check_eq("post_rst_idle_busy", 32'(busy0), 32'd0);

    // Start pulsed while busy must be ignored.
    run_gen(0, 1'b0, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
